// File: rtl/sdram_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Arbitrates the on-chip debug RAM between JTAG take_action pulses and the CPU Avalon debug slave.
// Define SDRAM_OCIMEM_ARB_FAIR_EN for round-robin arbitration; otherwise JTAG has fixed priority.
module sdram_nios2_gen2_0_cpu_ocimem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int PROT_WORDS = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    input  logic              avs_debugaccess,
    output logic              avs_waitrequest,
    output logic [31:0]       avs_readdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_byteen,
    output logic              ram_wren,
    output logic              ram_rden,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              jtag_ovf
);

    typedef enum logic [1:0] {ST_IDLE, ST_JACC, ST_CACC, ST_RDATA} state_t;

    localparam logic [ADDR_W:0] PROT_LIM = PROT_WORDS[ADDR_W:0];

    state_t            r_state;
    logic              r_jpend;
    logic              r_jwrite;
    logic [31:0]       r_jwdata;
    logic [ADDR_W-1:0] r_jtag_addr;
    logic              r_acc_write;
    logic              r_rd_src_j;
    logic              r_cpu_ack;
    logic              r_last_cpu;
    logic [31:0]       r_readdata;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [31:0]       r_ram_wdata;
    logic [3:0]        r_ram_byteen;
    logic              r_ram_wren;
    logic              r_ram_rden;
    logic [31:0]       r_mon;
    logic              r_mon_ready;
    logic              r_ovf;

    logic              w_cpu_req;
    logic              w_creq;
    logic              w_prot;
    logic              w_cpu_blk;
    logic              w_any_pulse;
    logic              w_jgrant;
    logic              w_cgrant;
    logic              w_unused;

    assign w_cpu_req   = avs_read | avs_write;
    // The request that was just acknowledged is still on the bus this cycle; it must not be re-granted.
    assign w_creq      = w_cpu_req & ~r_cpu_ack;
    assign w_prot      = ({1'b0, avs_address} < PROT_LIM);
    assign w_cpu_blk   = avs_write & w_prot & ~avs_debugaccess;
    assign w_any_pulse = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign w_unused    = ^{jdo[37:35], jdo[2:0]};

`ifdef SDRAM_OCIMEM_ARB_FAIR_EN
    assign w_jgrant = r_jpend & (~w_creq | r_last_cpu);
`else
    assign w_jgrant = r_jpend;
`endif
    assign w_cgrant = w_creq & ~w_jgrant;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_jpend      <= 1'b0;
            r_jwrite     <= 1'b0;
            r_jwdata     <= '0;
            r_jtag_addr  <= '0;
            r_acc_write  <= 1'b0;
            r_rd_src_j   <= 1'b0;
            r_cpu_ack    <= 1'b0;
            r_last_cpu   <= 1'b0;
            r_readdata   <= '0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_ram_byteen <= '0;
            r_ram_wren   <= 1'b0;
            r_ram_rden   <= 1'b0;
            r_mon        <= '0;
            r_mon_ready  <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_ram_wren <= 1'b0;
            r_ram_rden <= 1'b0;
            r_cpu_ack  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_jgrant) begin
                        r_state      <= ST_JACC;
                        r_jpend      <= 1'b0;
                        r_last_cpu   <= 1'b0;
                        r_acc_write  <= r_jwrite;
                        r_ram_addr   <= r_jtag_addr;
                        r_ram_wdata  <= r_jwdata;
                        r_ram_byteen <= 4'hF;
                        r_ram_wren   <= r_jwrite;
                        r_ram_rden   <= ~r_jwrite;
                    end else if (w_cgrant) begin
                        r_state      <= ST_CACC;
                        r_last_cpu   <= 1'b1;
                        r_acc_write  <= avs_write;
                        r_ram_addr   <= avs_address;
                        r_ram_wdata  <= avs_writedata;
                        r_ram_byteen <= avs_byteenable;
                        r_ram_wren   <= avs_write & ~w_cpu_blk;
                        r_ram_rden   <= ~avs_write;
                    end
                end
                ST_JACC: begin
                    // The address is consumed here, so stepping it now lets a later
                    // address load (below) override it cleanly.
                    r_jtag_addr <= r_jtag_addr + 1'b1;
                    if (r_acc_write) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state    <= ST_RDATA;
                        r_rd_src_j <= 1'b1;
                    end
                end
                ST_CACC: begin
                    if (r_acc_write) begin
                        r_cpu_ack <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_state    <= ST_RDATA;
                        r_rd_src_j <= 1'b0;
                    end
                end
                ST_RDATA: begin
                    if (r_rd_src_j) begin
                        r_mon       <= ram_rdata;
                        r_mon_ready <= 1'b1;
                    end else begin
                        r_readdata <= ram_rdata;
                        r_cpu_ack  <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            // One-deep JTAG command slot: ocimem_b beats ocimem_a beats no_action_a.
            if (w_any_pulse) begin
                if (r_jpend) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_mon_ready <= 1'b0;
                    if (take_action_ocimem_b) begin
                        r_jpend  <= 1'b1;
                        r_jwrite <= 1'b1;
                        r_jwdata <= jdo[34:3];
                    end else if (take_action_ocimem_a) begin
                        r_jtag_addr <= jdo[ADDR_W+17:18];
                        if (jdo[17]) begin
                            r_jpend  <= 1'b1;
                            r_jwrite <= 1'b0;
                        end
                    end else begin
                        r_jpend  <= 1'b1;
                        r_jwrite <= 1'b0;
                    end
                end
            end
        end
    end

    assign avs_waitrequest = w_cpu_req & ~r_cpu_ack;
    assign avs_readdata    = r_readdata;
    assign ram_addr        = r_ram_addr;
    assign ram_wdata       = r_ram_wdata;
    assign ram_byteen      = r_ram_byteen;
    assign ram_wren        = r_ram_wren;
    assign ram_rden        = r_ram_rden;
    assign MonDReg         = r_mon;
    assign monitor_ready   = r_mon_ready;
    assign jtag_ovf        = r_ovf;

endmodule
